// File: rtl/mips_mem_pkg.sv
// Shared definitions for the byte-serial load/store unit: access size
// encodings, FSM state type and small decode helpers.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Index of the final beat for a legal size (byte 0, half 1, word 3).
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_beat = 2'd0;
      SIZE_HALF: last_beat = 2'd1;
      default:   last_beat = 2'd3;
    endcase
  endfunction

  // Request is rejected without touching memory: illegal size or misaligned.
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: req_error = 1'b0;
      SIZE_HALF: req_error = addr_lo[0];
      SIZE_WORD: req_error = (addr_lo != 2'b00);
      default:   req_error = 1'b1;
    endcase
  endfunction

  // Left-justify store data so the first beat always takes bits [31:24].
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: store_align = {wdata[7:0], 24'h000000};
      SIZE_HALF: store_align = {wdata[15:0], 16'h0000};
      default:   store_align = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Size-based sign/zero extension of an assembled, right-justified load value.
module load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  // Extend byte/halfword from its top bit when signed, zeros otherwise.
  always_comb begin
    data_o = raw_i;
    case (size_i)
      SIZE_BYTE: data_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
      SIZE_HALF: data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default:   data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: turns byte/half/word CPU requests into
// big-endian sequences of single-byte memory accesses, one byte per cycle.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only while idle, and all req_* inputs are ignored otherwise.
// Completion is a single-cycle resp_valid pulse; resp_rdata/resp_err stay put
// until the next pulse.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data_out,
  input  logic [7:0]            mem_data_in,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            dbg_state_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  lsu_state_t            state_q;
  logic [1:0]            beat_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic                  signed_q;
  logic [31:0]           wdata_sh_q;
  logic [31:0]           asm_q;
  logic [31:0]           asm_d;
  logic [31:0]           ext_d;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [7:0]            mem_data_out_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [31:0]           store_first;

  // Next assembly value includes the byte arriving at the edge ending this beat.
  assign asm_d       = {asm_q[23:0], mem_data_in};
  assign store_first = store_align(req_size, req_wdata);

  load_extend u_load_extend (
    .raw_i    (asm_d),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_d)
  );

  // Request FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      beat_q         <= 2'd0;
      size_q         <= SIZE_BYTE;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      wdata_sh_q     <= 32'h0;
      asm_q          <= 32'h0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0;
      resp_err_q     <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= 8'h00;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            size_q   <= req_size;
            write_q  <= req_write;
            signed_q <= req_signed;
            beat_q   <= 2'd0;
            asm_q    <= 32'h0;
            if (req_error(req_size, req_addr[1:0])) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q        <= ST_ACCESS;
              mem_address_q  <= req_addr;
              mem_read_q     <= ~req_write;
              mem_write_q    <= req_write;
              mem_data_out_q <= req_write ? store_first[31:24] : 8'h00;
              wdata_sh_q     <= req_write ? {store_first[23:0], 8'h00} : 32'h0;
            end
          end
        end
        ST_ACCESS: begin
          asm_q  <= asm_d;
          beat_q <= beat_q + 2'd1;
          if (beat_q == last_beat(size_q)) begin
            state_q        <= ST_RESP;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_data_out_q <= 8'h00;
            resp_valid_q   <= 1'b1;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= write_q ? 32'h0 : ext_d;
          end else begin
            mem_address_q  <= mem_address_q + ADDR_ONE;
            mem_data_out_q <= wdata_sh_q[31:24];
            wdata_sh_q     <= {wdata_sh_q[23:0], 8'h00};
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-wide memory behind the unit, a
// transaction-level model of memory contents, directed and random requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  dbg_state;

  logic        mem_clear;
  logic [7:0]  mem     [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [40:0] exp_q[$];
  logic [31:0] last_rd;
  logic        last_err;
  int          n_checks = 0;
  int          n_errors = 0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Byte-wide memory, aliased on the low 8 address bits.
  assign mem_data_in = mem[mem_address[7:0]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[mem_address[7:0]] <= mem_data_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver + scoreboard for one request; expectations come from the model.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic hold);
    int          nb;
    int          lat;
    logic        err;
    logic [31:0] val;
    logic [31:0] exp_rd;
    logic [31:0] ak;
    logic [7:0]  b;
    logic [40:0] e;
    logic        seen;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    val = 32'h0;
    exp_q.delete();
    if (!err) begin
      for (int k = 0; k < nb; k++) begin
        ak = a + 32'(k);
        if (w) begin
          b = 8'(wd >> (8 * (nb - 1 - k)));
          ref_mem[ak[7:0]] = b;
        end else begin
          b = ref_mem[ak[7:0]];
          val = (val << 8) | {24'h0, b};
        end
        exp_q.push_back({w, ak, b});
      end
      if (!w && sg && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
    end
    exp_rd = (w || err) ? 32'h0 : val;
    lat    = err ? 1 : nb + 1;

    @(negedge clk);
    check("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("held_rdata", resp_rdata, last_rd);
    check("held_err", {31'h0, resp_err}, {31'h0, last_err});
    check("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    // Junk payload while busy; must be ignored even with valid held high.
    req_valid = hold; req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1)); req_addr = $urandom(); req_wdata = $urandom();
    seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", {30'h0, mem_read, mem_write}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", mem_address, e[39:8]);
          check("beat_write", {31'h0, mem_write}, {31'h0, e[40]});
          check("beat_read", {31'h0, mem_read}, {31'h0, ~e[40]});
          if (e[40]) check("beat_data", {24'h0, mem_data_out}, {24'h0, e[7:0]});
        end
      end
      if (resp_valid) begin
        seen = 1'b1;
        check("latency", 32'(c), 32'(lat));
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", {31'h0, resp_err}, {31'h0, err});
        check("ready_resp", {31'h0, req_ready}, 32'h0);
      end else begin
        check("ready_busy", {31'h0, req_ready}, 32'h0);
      end
    end
    if (!seen) check("resp_timeout", 32'h0, 32'h1);
    check("beats_left", 32'(exp_q.size()), 32'h0);
    last_rd  = exp_rd;
    last_err = err;
  endtask

  initial begin
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    last_rd = 32'h0; last_err = 1'b0;
    reset = 1'b1; mem_clear = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_data", {24'h0, mem_data_out}, 32'h0);
    reset = 1'b0; mem_clear = 1'b0;

    // Directed cases
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_1234, 1'b1);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h5555, 1'b1);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0102_8384, 1'b1);
    do_req(1'b0, 2'b10, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b0);

    // Reset in the middle of a word store
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hAABB_CCDD, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h5566_7788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_beat2_addr", mem_address, 32'h32);
    check("mid_beat2_write", {31'h0, mem_write}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    check("abort_mem_addr", mem_address, 32'h0);
    reset = 1'b0;
    ref_mem[8'h30] = 8'h55; ref_mem[8'h31] = 8'h66; ref_mem[8'h32] = 8'h77;
    last_rd = 32'h0; last_err = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(w, sz, 1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 1)));
    end

    req_valid = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, width of req_addr and mem_address.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  1  CPU access request.
REQ-005 Port: req_ready  out  1  unit idle, request accepted when req_valid && req_ready.
REQ-006 Port: req_write  in  1  1 = store, 0 = load.
REQ-007 Port: req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 Port: req_signed  in  1  loads only, sign-extend byte/halfword.
REQ-009 Port: req_addr  in  ADDR_WIDTH  byte address.
REQ-010 Port: req_wdata  in  32  store data, right-justified.
REQ-011 Port: resp_valid  out  1  one-cycle completion pulse.
REQ-012 Port: resp_rdata  out  32  load result.
REQ-013 Port: resp_err  out  1  misaligned or illegal-size request, valid with resp_valid.
REQ-014 Port: mem_address  out  ADDR_WIDTH  byte address to byte-wide data memory.
REQ-015 Port: mem_data_out  out  8  store byte to memory data input.
REQ-016 Port: mem_data_in  in  8  combinational read byte from memory.
REQ-017 Port: mem_read, mem_write  out  1 each  memory strobes.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on accept, latch addr/wdata/size/write/signed, beat counter := 0, go ACCESS; if misaligned (half: addr[0]=1; word: addr[1:0]!=0) or size=11, go RESP with err, no memory strobe.
REQ-020 ACCESS: one byte per cycle, N = 1/2/4 beats; mem_address = latched addr + beat; mem_read = !write, mem_write = write; both 0 outside ACCESS.
REQ-021 Byte order big-endian: beat 0 = most significant byte of the accessed quantity.
REQ-022 Stores: beat k drives byte (N-1-k) of req_wdata (e.g. word beat 0 = wdata[31:24]).
REQ-023 Loads: mem_data_in sampled at the rising edge ending each beat and shifted into an assembly register.
REQ-024 After beat N-1, go RESP; RESP lasts one cycle with resp_valid=1, then IDLE.
REQ-025 Latency: accept at edge 0, resp_valid high during cycle N+1; error responses during cycle 1.
REQ-026 resp_rdata: byte/half zero- or sign-extended per req_signed, word as assembled; 0 for stores and errors; held until next resp_valid.
REQ-027 resp_err = 1 only for REQ-019 error cases, 0 otherwise; held with resp_rdata.
REQ-028 Address increment wraps modulo 2^ADDR_WIDTH; no error raised.
REQ-029 Requests while busy are not accepted; req_* inputs ignored outside IDLE.
REQ-030 Back-to-back: new request acceptable in the IDLE cycle immediately following RESP.

Reset
REQ-031 On reset: state IDLE, beat counter 0, resp_valid 0, resp_rdata 0, resp_err 0, mem_read 0, mem_write 0, mem_address 0, mem_data_out 0, req_ready 1 from the next cycle.
REQ-032 Reset mid-ACCESS aborts the transaction; no resp_valid produced for it; strobes low from the next cycle.

Structure
REQ-033 Shared package mips_mem_pkg SHALL hold size encodings (SIZE_BYTE/HALF/WORD) and FSM state type.
REQ-034 One combinational sub-module load_extend SHALL perform size-based sign/zero extension.

Verification
REQ-035 Store word 0xDEADBEEF at 0x10 -> 4 write beats at 0x10..0x13 with bytes DE,AD,BE,EF; resp_valid cycle 5, resp_err 0.
REQ-036 Load word 0x10 after REQ-035 -> resp_rdata 0xDEADBEEF at cycle 5; load signed byte 0x12 -> 0xFFFFFFBE; unsigned -> 0x000000BE.
REQ-037 Load signed half 0x12 -> 0xFFFFBEEF; store half 0x1234 at 0x20 then load -> 0x00001234.
REQ-038 Word load at 0x11, half store at 0x21, size=11 -> resp_err 1, resp_rdata 0, no mem strobe, resp_valid cycle 1.
REQ-039 Reset asserted during beat 2 of word store -> no resp_valid, strobes low next cycle, req_ready 1; byte 0x13 unchanged.
REQ-040 req_valid held high across busy window and back-to-back requests -> exactly one accept per IDLE cycle.
